// File: rtl/crc_stream.sv
// crc_stream: streaming CRC engine. Folds one DATA_WIDTH beat per cycle into
// the CRC register and presents the finished frame CRC plus beat count on a
// valid/ready result port. A new frame cannot start until the result is taken.
module crc_stream #(
  parameter int                   DATA_WIDTH  = 8,
  parameter int                   CRC_WIDTH   = 16,
  parameter logic [31:0]          POLY        = 32'h0000_8005,
  parameter logic [CRC_WIDTH-1:0] INIT        = '0,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT     = '0,
  parameter bit                   REFLECT_IN  = 1'b0,
  parameter bit                   REFLECT_OUT = 1'b0,
  parameter int                   CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_last,
  output logic                  crc_valid,
  input  logic                  crc_ready,
  output logic [CRC_WIDTH-1:0]  crc_out,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  frame_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CRC_WIDTH-1:0] POLY_W = POLY[CRC_WIDTH-1:0];

  state_t                 state, state_nxt;
  logic [CRC_WIDTH-1:0]   crc_q, crc_nxt, crc_base, crc_upd;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_nxt;
  logic                   err_nxt, load_res, accept;

  // Whole beat folded in one cycle, MSB first; optional per-byte bit reversal.
  function automatic logic [CRC_WIDTH-1:0] crc_update(
    input logic [CRC_WIDTH-1:0]  c,
    input logic [DATA_WIDTH-1:0] beat
  );
    logic [CRC_WIDTH-1:0]  r;
    logic [DATA_WIDTH-1:0] b;
    logic                  d;
    b = beat;
    if (REFLECT_IN)
      for (int i = 0; i < DATA_WIDTH; i++) b[i] = beat[(i/8)*8 + 7 - (i%8)];
    r = c;
    for (int i = DATA_WIDTH-1; i >= 0; i--) begin
      d = b[i] ^ r[CRC_WIDTH-1];
      r = (r << 1) ^ (d ? POLY_W : '0);
    end
    return r;
  endfunction

  // Output conditioning applied once, when the result is latched.
  function automatic logic [CRC_WIDTH-1:0] crc_final(input logic [CRC_WIDTH-1:0] c);
    logic [CRC_WIDTH-1:0] r;
    r = c;
    if (REFLECT_OUT)
      for (int i = 0; i < CRC_WIDTH; i++) r[i] = c[CRC_WIDTH-1-i];
    return r ^ XOR_OUT;
  endfunction

  assign in_ready  = (state != HOLD);
  assign crc_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // A beat restarts from INIT when it opens a frame (implicitly in IDLE, or
  // an explicit sop mid-frame); otherwise it continues the running CRC.
  assign crc_base = (state == IDLE || in_sop) ? INIT : crc_q;
  assign crc_upd  = crc_update(crc_base, in_data);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, next CRC/count, framing error and result-load strobe.
  always_comb begin
    state_nxt = state;
    crc_nxt   = crc_q;
    cnt_nxt   = cnt_q;
    err_nxt   = 1'b0;
    load_res  = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          crc_nxt = crc_upd;
          if (state == IDLE || in_sop) begin
            cnt_nxt = CNT_WIDTH'(1);
            err_nxt = (state == IDLE) ? !in_sop : 1'b1;
          end else begin
            cnt_nxt = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          end
          if (in_last) begin
            state_nxt = HOLD;
            load_res  = 1'b1;
          end else begin
            state_nxt = ACCUM;
          end
        end
      end
      HOLD:    if (crc_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers; the result is frozen for the whole HOLD period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= INIT;
      cnt_q     <= '0;
      crc_out   <= '0;
      beat_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      crc_q     <= crc_nxt;
      cnt_q     <= cnt_nxt;
      frame_err <= err_nxt;
      if (load_res) begin
        crc_out  <= crc_final(crc_nxt);
        beat_cnt <= cnt_nxt;
      end
    end
  end

endmodule
